// File: rtl/uart_wb_arbiter.sv
// Round-robin arbiter sharing the uart register port between two masters.
// Requests are serialised onto one strobe/ack bus, guarded by a timeout.
module uart_wb_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_data_in,
    output logic [DATA_W-1:0] m0_data_out,
    input  logic              m0_we,
    input  logic              m0_stb,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_data_in,
    output logic [DATA_W-1:0] m1_data_out,
    input  logic              m1_we,
    input  logic              m1_stb,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_data_out,
    input  logic [DATA_W-1:0] s_data_in,
    output logic              s_we,
    output logic              s_stb,
    input  logic              s_ack,
    output logic              owner
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        DONE,
        ERR,
        DRAIN
    } state_e;

    // Counter hits this value on the cycle the timeout fires.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e                   state_q, state_d;
    logic                     owner_q, owner_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [ADDR_W-1:0]        s_addr_q, s_addr_d;
    logic [DATA_W-1:0]        s_data_q, s_data_d;
    logic                     s_we_q, s_we_d;
    logic                     s_stb_q, s_stb_d;
    logic [1:0]               ack_q, ack_d;
    logic [1:0]               err_q, err_d;
    logic [1:0][DATA_W-1:0]   dout_q, dout_d;

    logic win;
    logic own_stb;

    // On a tie the master that was not granted last wins.
    assign win     = (m0_stb && m1_stb) ? ~owner_q : m1_stb;
    assign own_stb = owner_q ? m1_stb : m0_stb;

    // Next-state and registered-output logic of the grant FSM.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        s_addr_d = s_addr_q;
        s_data_d = s_data_q;
        s_we_d   = s_we_q;
        s_stb_d  = s_stb_q;
        ack_d    = ack_q;
        err_d    = err_q;
        dout_d   = dout_q;
        unique case (state_q)
            IDLE: begin
                if (m0_stb || m1_stb) begin
                    owner_d  = win;
                    s_addr_d = win ? m1_addr : m0_addr;
                    s_data_d = win ? m1_data_in : m0_data_in;
                    s_we_d   = win ? m1_we : m0_we;
                    s_stb_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (s_ack) begin
                    if (s_we_q) begin
                        dout_d[owner_q] = s_data_in;
                    end
                    ack_d[owner_q] = 1'b1;
                    state_d        = DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_d[owner_q] = 1'b1;
                    s_stb_d        = 1'b0;
                    state_d        = ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                if (!own_stb) begin
                    ack_d   = '0;
                    s_stb_d = 1'b0;
                    state_d = DRAIN;
                end
            end
            ERR: begin
                if (!own_stb) begin
                    err_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!s_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves m0 winning the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b1;
            cnt_q    <= '0;
            s_addr_q <= '0;
            s_data_q <= '0;
            s_we_q   <= 1'b0;
            s_stb_q  <= 1'b0;
            ack_q    <= '0;
            err_q    <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            s_addr_q <= s_addr_d;
            s_data_q <= s_data_d;
            s_we_q   <= s_we_d;
            s_stb_q  <= s_stb_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            dout_q   <= dout_d;
        end
    end

    assign m0_ack      = ack_q[0];
    assign m1_ack      = ack_q[1];
    assign m0_err      = err_q[0];
    assign m1_err      = err_q[1];
    assign m0_data_out = dout_q[0];
    assign m1_data_out = dout_q[1];
    assign s_addr      = s_addr_q;
    assign s_data_out  = s_data_q;
    assign s_we        = s_we_q;
    assign s_stb       = s_stb_q;
    assign owner       = owner_q;

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Scoreboard bench for uart_wb_arbiter: random masters, random slave,
// grant/response expectations from a round-robin reference model.
module tb_uart_wb_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] m0_addr, m1_addr, s_addr;
    logic [7:0]  m0_data_in, m1_data_in, m0_data_out, m1_data_out;
    logic [7:0]  s_data_out, s_data_in;
    logic        m0_we, m1_we, m0_stb, m1_stb;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic        s_we, s_stb, s_ack, owner;

    uart_wb_arbiter #(.ADDR_W(12), .DATA_W(8), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_data_in(m0_data_in),
        .m0_data_out(m0_data_out), .m0_we(m0_we), .m0_stb(m0_stb),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_data_in(m1_data_in),
        .m1_data_out(m1_data_out), .m1_we(m1_we), .m1_stb(m1_stb),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .s_addr(s_addr), .s_data_out(s_data_out), .s_data_in(s_data_in),
        .s_we(s_we), .s_stb(s_stb), .s_ack(s_ack), .owner(owner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Slave behaviour knobs (-1 = random).
    int          force_delay = -1;
    int          force_hold  = -1;
    int          force_rdata = -1;
    bit          force_noack = 0;
    bit          rand_noack  = 0;
    bit          sl_noack;
    logic [7:0]  sl_rdata;
    int          sl_st, sl_cnt, sl_hold;

    // 4-phase uart slave model.
    initial begin
        s_ack = 1'b0;
        s_data_in = 8'h00;
        sl_st = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                s_ack = 1'b0;
                sl_st = 0;
            end else begin
                case (sl_st)
                    0: if (s_stb) begin
                        sl_noack = force_noack ||
                                   (rand_noack && $urandom_range(0, 7) == 0);
                        sl_rdata = (force_rdata >= 0) ? 8'(force_rdata)
                                                      : 8'($urandom);
                        sl_cnt = (force_delay >= 0) ? force_delay
                                                    : $urandom_range(0, 4);
                        sl_hold = (force_hold >= 0) ? force_hold
                                                    : $urandom_range(0, 3);
                        if (sl_noack) sl_st = 3;
                        else if (sl_cnt == 0) begin
                            s_ack = 1'b1;
                            s_data_in = sl_rdata;
                            sl_st = 2;
                        end else sl_st = 1;
                    end
                    1: begin
                        sl_cnt--;
                        if (sl_cnt == 0) begin
                            s_ack = 1'b1;
                            s_data_in = sl_rdata;
                            sl_st = 2;
                        end
                    end
                    2: if (!s_stb) begin
                        if (sl_hold == 0) begin
                            s_ack = 1'b0;
                            sl_st = 0;
                        end else sl_st = 4;
                    end
                    3: if (!s_stb) sl_st = 0;
                    4: begin
                        sl_hold--;
                        if (sl_hold == 0) begin
                            s_ack = 1'b0;
                            sl_st = 0;
                        end
                    end
                    default: sl_st = 0;
                endcase
            end
        end
    end

    // Reference model + scoreboard.
    typedef struct {
        bit         m;
        bit         err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          glog[$];
    int          cyc = 0;
    int          low_cnt = 2;
    int          sack_cyc = -10;
    int          first_w = -1;
    int          ecyc;
    bit          own_m = 1;
    bit          w;
    logic [7:0]  dout_m[2];
    logic [7:0]  dout_v[2];
    logic [1:0]  p_stb, p_ack, p_err, ack_v, err_v;
    logic [11:0] p_addr[2];
    logic [7:0]  p_data[2];
    logic        p_we[2];
    logic        p_s_stb, p_s_ack;

    initial begin
        dout_m[0] = 8'h00;
        dout_m[1] = 8'h00;
        p_stb = 2'b00; p_ack = 2'b00; p_err = 2'b00;
        p_s_stb = 1'b0; p_s_ack = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            ack_v = {m1_ack, m0_ack};
            err_v = {m1_err, m0_err};
            dout_v[0] = m0_data_out;
            dout_v[1] = m1_data_out;
            if (reset) begin
                sb.delete();
                own_m = 1;
                dout_m[0] = 8'h00;
                dout_m[1] = 8'h00;
                low_cnt = 2;
                first_w = -1;
            end else begin
                chk("excl", {ack_v == 2'b11, (ack_v & err_v) != 2'b00}, 0);
                for (int i = 0; i < 2; i++) begin
                    if ((ack_v[i] && !p_ack[i]) || (err_v[i] && !p_err[i])) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_resp", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            ecyc = e.err ? e.cyc : sack_cyc + 1;
                            chk("resp", {1'(i), err_v[i], dout_v[i], 32'(cyc)},
                                {e.m, e.err, e.data, 32'(ecyc)});
                            chk("other_dout", dout_v[1-i], dout_m[1-i]);
                            if (err_v[i]) chk("err_stb_low", s_stb, 0);
                        end
                    end
                end
                if (s_stb && !p_s_stb) begin
                    chk("ack_low_at_grant", p_s_ack, 0);
                    chk("grant_gap", low_cnt >= 2, 1);
                    chk("grant_has_req", p_stb != 2'b00, 1);
                    if (p_stb == 2'b11) w = !own_m;
                    else w = p_stb[1];
                    chk("grant", {owner, s_we, s_addr, s_data_out},
                        {w, p_we[w], p_addr[w], p_data[w]});
                    own_m = w;
                    if (first_w < 0) first_w = int'(w);
                    glog.push_back(int'(w));
                    sack_cyc = -10;
                    if (!sl_noack && p_we[w]) dout_m[w] = sl_rdata;
                    e.m = w;
                    e.err = sl_noack;
                    e.data = dout_m[w];
                    e.cyc = cyc + TO;
                    sb.push_back(e);
                end
                if (s_ack && !p_s_ack && s_stb) sack_cyc = cyc;
                if (s_stb) low_cnt = 0;
                else low_cnt++;
            end
            p_stb = {m1_stb, m0_stb};
            p_addr[0] = m0_addr; p_addr[1] = m1_addr;
            p_data[0] = m0_data_in; p_data[1] = m1_data_in;
            p_we[0] = m0_we; p_we[1] = m1_we;
            p_s_stb = s_stb;
            p_s_ack = s_ack;
            p_ack = ack_v;
            p_err = err_v;
        end
    end

    task automatic set_stb(input int m, input logic v);
        if (m == 0) m0_stb = v;
        else m1_stb = v;
    endtask

    // One master transaction: raise stb, wait for ack/err, drop stb.
    task automatic do_txn(input int m, input logic [11:0] a,
                          input logic [7:0] d, input logic we,
                          input bit early, output bit got_err);
        bit got = 0;
        got_err = 0;
        @(posedge clk);
        #1;
        if (m == 0) begin
            m0_addr = a; m0_data_in = d; m0_we = we; m0_stb = 1'b1;
        end else begin
            m1_addr = a; m1_data_in = d; m1_we = we; m1_stb = 1'b1;
        end
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (m == 0) begin
                got = m0_ack | m0_err;
                got_err = m0_err;
            end else begin
                got = m1_ack | m1_err;
                got_err = m1_err;
            end
            if (!got && early && s_stb && owner == 1'(m)) begin
                early = 0;
                @(posedge clk);
                #1 set_stb(m, 1'b0);
            end
        end
        chk("txn_done", got, 1);
        @(posedge clk);
        #1 set_stb(m, 1'b0);
    endtask

    bit ge, ge0, ge1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        m0_addr = '0; m0_data_in = '0; m0_we = 1'b0; m0_stb = 1'b0;
        m1_addr = '0; m1_data_in = '0; m1_we = 1'b0; m1_stb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {m0_ack, m1_ack, m0_err, m1_err, s_stb, s_we, owner},
            7'b0000001);
        chk("rst_data", {s_addr, s_data_out, m0_data_out, m1_data_out}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        force_hold = 0;
        force_delay = 2;
        do_txn(0, 12'h000, 8'h41, 1'b0, 0, ge);
        chk("p1_m1_quiet", {m1_data_out, m1_ack, m1_err}, 0);
        chk("p1_m0_dout", m0_data_out, 8'h00);

        force_rdata = 8'h5A;
        do_txn(1, 12'h001, 8'h00, 1'b1, 0, ge);
        chk("p2_m1_dout", m1_data_out, 8'h5A);
        chk("p2_m0_dout", m0_data_out, 8'h00);
        force_rdata = -1;
        force_delay = -1;

        glog.delete();
        fork
            for (int i = 0; i < 6; i++)
                do_txn(0, 12'($urandom_range(0, 2)), 8'($urandom),
                       1'($urandom), 0, ge0);
            for (int i = 0; i < 6; i++)
                do_txn(1, 12'($urandom_range(0, 2)), 8'($urandom),
                       1'($urandom), 0, ge1);
        join
        chk("p3_grants", glog.size(), 12);
        for (int i = 1; i < glog.size(); i++)
            chk("p3_alternate", glog[i] != glog[i-1], 1);

        force_noack = 1;
        do_txn(0, 12'h002, 8'h10, 1'b0, 0, ge);
        chk("p4_err", ge, 1);
        force_noack = 0;
        do_txn(0, 12'h002, 8'h10, 1'b0, 0, ge);
        chk("p4_recover", ge, 0);

        force_hold = 5;
        fork
            do_txn(0, 12'h000, 8'h33, 1'b0, 0, ge0);
            begin
                repeat (2) @(posedge clk);
                do_txn(1, 12'h001, 8'h00, 1'b1, 0, ge1);
            end
        join
        force_hold = -1;

        rand_noack = 1;
        fork
            for (int i = 0; i < 25; i++)
                do_txn(0, 12'($urandom), 8'($urandom), 1'($urandom),
                       $urandom_range(0, 3) == 0, ge0);
            for (int i = 0; i < 25; i++)
                do_txn(1, 12'($urandom), 8'($urandom), 1'($urandom),
                       $urandom_range(0, 3) == 0, ge1);
        join
        rand_noack = 0;

        force_noack = 1;
        @(posedge clk);
        #1;
        m0_addr = 12'h001; m0_we = 1'b1; m0_stb = 1'b1;
        for (int k = 0; k < 20 && !s_stb; k++) @(negedge clk);
        chk("p7_granted", s_stb, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m0_stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("p7_reset", {s_stb, m0_ack, m1_ack, m0_err, m1_err, owner},
            6'b000001);
        @(posedge clk);
        #1;
        reset = 1'b0;
        force_noack = 0;
        fork
            do_txn(0, 12'h000, 8'h77, 1'b0, 0, ge0);
            do_txn(1, 12'h000, 8'h88, 1'b0, 0, ge1);
        join
        chk("p7_first_m0", first_w, 0);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
